uart_dbg_bridge: RTL and testbench



---
 rtl/uart_dbg_bridge_pkg.sv | 34 +++
 rtl/uart_byte_rx.sv | 93 +++++++++
 rtl/uart_dbg_bridge.sv | 198 +++++++++++++++++++
 tb/tb_uart_dbg_bridge.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_dbg_bridge_pkg.sv
// Shared command codes, divider default and state encodings for the UART debug bridge.
`ifndef CPU_CLOCK_HZ
`define CPU_CLOCK_HZ 50000000
`endif

package uart_dbg_bridge_pkg;

   localparam logic [7:0] CMD_WR = 8'h57;
   localparam logic [7:0] CMD_RD = 8'h52;
   localparam logic [7:0] ACK    = 8'h4B;

   localparam int unsigned DEFAULT_BAUD_DIV = `CPU_CLOCK_HZ / 115200;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

   typedef enum logic [2:0] {
      P_IDLE,
      P_ADDR,
      P_DATA,
      P_BUS,
      P_RD_WAIT,
      P_RESP
   } parser_state_t;

   function automatic logic is_cmd(input logic [7:0] b);
      return (b == CMD_WR) || (b == CMD_RD);
   endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 byte receiver: input synchronizer, start-bit validation, mid-bit sampling and stop-bit check.
module uart_byte_rx
   import uart_dbg_bridge_pkg::*;
#(
   parameter int unsigned BAUD_DIV = DEFAULT_BAUD_DIV
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_pin,
   output logic [7:0] byte_o,
   output logic       valid_o,
   output logic       ferr_o
);

   localparam int unsigned CNT_W = $clog2(BAUD_DIV);
   // Half-bit count is taken from the synchronized edge, which the detector sees one cycle late.
   localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(BAUD_DIV / 2 - 2);
   localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(BAUD_DIV - 1);

   logic            r_sync1;
   logic            r_sync2;
   logic            r_sync3;
   rx_state_t       r_state;
   rx_state_t       w_state_next;
   logic [CNT_W-1:0] r_cnt;
   logic [2:0]      r_bit;
   logic [7:0]      r_shift;
   logic [7:0]      r_byte;
   logic            r_valid;
   logic            r_ferr;
   logic            w_fall;
   logic            w_tick;

   assign w_fall = r_sync3 & ~r_sync2;
   assign w_tick = (r_cnt == '0);

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         RX_IDLE:  if (w_fall) w_state_next = RX_START;
         RX_START: if (w_tick) w_state_next = r_sync2 ? RX_IDLE : RX_DATA;
         RX_DATA:  if (w_tick && (r_bit == 3'd7)) w_state_next = RX_STOP;
         RX_STOP:  if (w_tick) w_state_next = RX_IDLE;
         default:  w_state_next = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_sync3 <= 1'b1;
         r_state <= RX_IDLE;
         r_cnt   <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_byte  <= '0;
         r_valid <= 1'b0;
         r_ferr  <= 1'b0;
      end else begin
         r_sync1 <= rx_pin;
         r_sync2 <= r_sync1;
         r_sync3 <= r_sync2;
         r_state <= w_state_next;
         r_valid <= 1'b0;
         r_ferr  <= 1'b0;
         if (r_state == RX_IDLE) begin
            r_cnt <= HALF_LOAD;
            r_bit <= '0;
         end else begin
            r_cnt <= w_tick ? FULL_LOAD : r_cnt - 1'b1;
         end
         if ((r_state == RX_DATA) && w_tick) begin
            r_shift <= {r_sync2, r_shift[7:1]};
            r_bit   <= r_bit + 3'd1;
         end
         if ((r_state == RX_STOP) && w_tick) begin
            if (r_sync2) begin
               r_valid <= 1'b1;
               r_byte  <= r_shift;
            end else begin
               r_ferr <= 1'b1;
            end
         end
      end
   end

   assign byte_o  = r_byte;
   assign valid_o = r_valid;
   assign ferr_o  = r_ferr;

endmodule

// File: rtl/uart_dbg_bridge.sv
// Serial debug bridge: parses W/R command frames, drives single register-bus accesses, answers over TX.
module uart_dbg_bridge
   import uart_dbg_bridge_pkg::*;
#(
   parameter int unsigned BAUD_DIV      = DEFAULT_BAUD_DIV,
   parameter int unsigned TIMEOUT_BYTES = 4
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        rx_pin,
   output logic        tx_pin,
   output logic [31:0] waddr_o,
   output logic [31:0] data_o,
   output logic [3:0]  sel_o,
   output logic        we_o,
   output logic [31:0] raddr_o,
   output logic        rd_o,
   input  logic [31:0] data_i,
   output logic        busy_o
);

   localparam int unsigned CNT_W  = $clog2(BAUD_DIV);
   localparam int unsigned TO_CYC = TIMEOUT_BYTES * 10 * BAUD_DIV;
   localparam int unsigned TO_W   = $clog2(TO_CYC + 1);
   localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(BAUD_DIV - 1);
   localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TO_CYC - 1);

   logic [7:0]       w_rx_byte;
   logic             w_rx_valid;
   logic             w_rx_ferr;

   parser_state_t    r_state;
   parser_state_t    w_state_next;
   logic             r_is_rd;
   logic [1:0]       r_byte_cnt;
   logic [31:0]      r_waddr;
   logic [31:0]      r_raddr;
   logic [31:0]      r_wdata;
   logic [23:0]      r_rdata;
   logic [1:0]       r_resp_left;
   logic [TO_W-1:0]  r_to_cnt;
   logic             w_timeout;
   logic             w_tx_start;
   logic [7:0]       w_tx_data;
   logic             w_tx_done;

   logic             r_tx_active;
   logic [CNT_W-1:0] r_tx_cnt;
   logic [3:0]       r_tx_bit;
   logic [7:0]       r_tx_shift;
   logic             r_tx_pin;

   uart_byte_rx #(
      .BAUD_DIV (BAUD_DIV)
   ) u_rx (
      .clk     (clk),
      .rst     (rst),
      .rx_pin  (rx_pin),
      .byte_o  (w_rx_byte),
      .valid_o (w_rx_valid),
      .ferr_o  (w_rx_ferr)
   );

   assign w_timeout = (r_to_cnt == TO_LAST);
   assign w_tx_done = r_tx_active && (r_tx_cnt == '0) && (r_tx_bit == 4'd9);

   // Framing errors only abort a frame still being received; once the bus phase starts,
   // every incoming byte (errored or not) is simply discarded.
   always_comb begin
      w_state_next = r_state;
      w_tx_start   = 1'b0;
      w_tx_data    = ACK;
      case (r_state)
         P_IDLE: begin
            if (w_rx_valid && is_cmd(w_rx_byte)) w_state_next = P_ADDR;
         end
         P_ADDR: begin
            if (w_rx_ferr) w_state_next = P_IDLE;
            else if (w_rx_valid) begin
               if (r_byte_cnt == 2'd3) w_state_next = r_is_rd ? P_BUS : P_DATA;
            end else if (w_timeout) w_state_next = P_IDLE;
         end
         P_DATA: begin
            if (w_rx_ferr) w_state_next = P_IDLE;
            else if (w_rx_valid) begin
               if (r_byte_cnt == 2'd3) w_state_next = P_BUS;
            end else if (w_timeout) w_state_next = P_IDLE;
         end
         P_BUS: begin
            if (r_is_rd) w_state_next = P_RD_WAIT;
            else begin
               w_state_next = P_RESP;
               w_tx_start   = 1'b1;
               w_tx_data    = ACK;
            end
         end
         P_RD_WAIT: begin
            w_state_next = P_RESP;
            w_tx_start   = 1'b1;
            w_tx_data    = data_i[31:24];
         end
         P_RESP: begin
            if (w_tx_done) begin
               if (r_resp_left == 2'd0) w_state_next = P_IDLE;
               else begin
                  w_tx_start = 1'b1;
                  w_tx_data  = r_rdata[23:16];
               end
            end
         end
         default: w_state_next = P_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= P_IDLE;
         r_is_rd     <= 1'b0;
         r_byte_cnt  <= '0;
         r_waddr     <= '0;
         r_raddr     <= '0;
         r_wdata     <= '0;
         r_rdata     <= '0;
         r_resp_left <= '0;
         r_to_cnt    <= '0;
      end else begin
         r_state <= w_state_next;

         if (w_rx_valid || !((r_state == P_ADDR) || (r_state == P_DATA))) r_to_cnt <= '0;
         else r_to_cnt <= r_to_cnt + 1'b1;

         if ((r_state == P_IDLE) && w_rx_valid && is_cmd(w_rx_byte)) begin
            r_is_rd    <= (w_rx_byte == CMD_RD);
            r_byte_cnt <= '0;
         end
         if ((r_state == P_ADDR) && w_rx_valid) begin
            r_waddr    <= {r_waddr[23:0], w_rx_byte};
            r_raddr    <= {r_raddr[23:0], w_rx_byte};
            r_byte_cnt <= r_byte_cnt + 2'd1;
         end
         if ((r_state == P_DATA) && w_rx_valid) begin
            r_wdata    <= {r_wdata[23:0], w_rx_byte};
            r_byte_cnt <= r_byte_cnt + 2'd1;
         end

         if (r_state == P_RD_WAIT) begin
            r_rdata     <= data_i[23:0];
            r_resp_left <= 2'd3;
         end else if ((r_state == P_BUS) && !r_is_rd) begin
            r_resp_left <= 2'd0;
         end else if ((r_state == P_RESP) && w_tx_done && (r_resp_left != 2'd0)) begin
            r_rdata     <= {r_rdata[15:0], 8'h00};
            r_resp_left <= r_resp_left - 2'd1;
         end
      end
   end

   // TX shifter: bit 0 is the start bit, 1..8 data, 9 stop.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tx_active <= 1'b0;
         r_tx_cnt    <= '0;
         r_tx_bit    <= '0;
         r_tx_shift  <= '0;
         r_tx_pin    <= 1'b1;
      end else if (w_tx_start) begin
         r_tx_active <= 1'b1;
         r_tx_cnt    <= FULL_LOAD;
         r_tx_bit    <= '0;
         r_tx_shift  <= w_tx_data;
         r_tx_pin    <= 1'b0;
      end else if (r_tx_active) begin
         if (r_tx_cnt == '0) begin
            r_tx_cnt <= FULL_LOAD;
            if (r_tx_bit == 4'd9) begin
               r_tx_active <= 1'b0;
            end else begin
               r_tx_bit   <= r_tx_bit + 4'd1;
               r_tx_pin   <= (r_tx_bit == 4'd8) ? 1'b1 : r_tx_shift[0];
               r_tx_shift <= {1'b0, r_tx_shift[7:1]};
            end
         end else begin
            r_tx_cnt <= r_tx_cnt - 1'b1;
         end
      end
   end

   assign we_o    = (r_state == P_BUS) && !r_is_rd;
   assign rd_o    = (r_state == P_BUS) && r_is_rd;
   assign sel_o   = {4{we_o}};
   assign busy_o  = (r_state != P_IDLE);
   assign waddr_o = r_waddr;
   assign raddr_o = r_raddr;
   assign data_o  = r_wdata;
   assign tx_pin  = r_tx_pin;

endmodule

// File: tb/tb_uart_dbg_bridge.sv
// Directed bench for uart_dbg_bridge at BAUD_DIV=8: write, read, framing error, timeout, reset mid-response.
`timescale 1ns/1ps
module tb_uart_dbg_bridge;

   localparam int B = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rx_pin = 1'b1;
   logic        tx_pin;
   logic [31:0] waddr_o;
   logic [31:0] data_o;
   logic [3:0]  sel_o;
   logic        we_o;
   logic [31:0] raddr_o;
   logic        rd_o;
   logic [31:0] data_i = 32'hDEADBEEF;
   logic        busy_o;

   always #5 clk = ~clk;

   uart_dbg_bridge #(.BAUD_DIV(B), .TIMEOUT_BYTES(4)) dut (
      .clk     (clk),
      .rst     (rst),
      .rx_pin  (rx_pin),
      .tx_pin  (tx_pin),
      .waddr_o (waddr_o),
      .data_o  (data_o),
      .sel_o   (sel_o),
      .we_o    (we_o),
      .raddr_o (raddr_o),
      .rd_o    (rd_o),
      .data_i  (data_i),
      .busy_o  (busy_o)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end else begin
         $display("ok   %s: %h", tag, got);
      end
   endtask

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Responder registers its read data: valid only in the cycle after rd_o.
   always @(posedge clk) data_i <= rd_o ? 32'h000000A5 : 32'hDEADBEEF;

   int          we_cnt = 0, rd_cnt = 0, sel_bad = 0;
   int          we_cyc = 0, rd_cyc = 0, busy_fall_cyc = 0;
   logic [31:0] we_addr = '0, we_data = '0, rd_addr = '0;
   logic [3:0]  we_sel = '0;
   logic        busy_prev = 1'b0;

   always @(negedge clk) begin
      if (we_o) begin
         we_cnt++; we_cyc = cyc; we_addr = waddr_o; we_data = data_o; we_sel = sel_o;
      end
      if (rd_o) begin
         rd_cnt++; rd_cyc = cyc; rd_addr = raddr_o;
      end
      if (!we_o && (sel_o != 4'h0)) sel_bad++;
      if (busy_prev && !busy_o) busy_fall_cyc = cyc;
      busy_prev = busy_o;
   end

   // Serial decoder for tx_pin; an in-flight byte is abandoned if rst is seen.
   logic [7:0] tx_q[$];
   int         start_q[$];

   task automatic wait_cyc(input int n, inout logic ab);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (rst) ab = 1'b1;
      end
   endtask

   int         d_start;
   logic [7:0] d_byte;
   logic       d_ab;
   logic       d_stop;
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && (tx_pin === 1'b0)) begin
            d_start = cyc;
            d_ab = 1'b0;
            d_byte = '0;
            wait_cyc(B / 2, d_ab);
            for (int i = 0; i < 8; i++) begin
               wait_cyc(B, d_ab);
               d_byte[i] = tx_pin;
            end
            wait_cyc(B, d_ab);
            d_stop = tx_pin;
            if (!d_ab) begin
               tx_q.push_back(d_byte);
               start_q.push_back(d_start);
               check("tx_stop_bit", 32'(d_stop), 32'd1);
            end
         end
      end
   end

   function automatic logic [31:0] q_byte(input int i);
      return (tx_q.size() > i) ? 32'(tx_q[i]) : 32'hFFFF_FFFF;
   endfunction

   function automatic int q_start(input int i);
      return (start_q.size() > i) ? start_q[i] : -1000;
   endfunction

   int last_start = 0;

   task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
      @(negedge clk);
      last_start = cyc;
      rx_pin = 1'b0;
      repeat (B) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx_pin = b[i];
         repeat (B) @(negedge clk);
      end
      rx_pin = stop;
      repeat (B) @(negedge clk);
      rx_pin = 1'b1;
   endtask

   task automatic send_cmd(input logic [7:0] cmd, input logic [31:0] addr, input logic [31:0] wdat,
                           input logic with_data);
      send_byte(cmd);
      for (int i = 3; i >= 0; i--) send_byte(addr[8*i +: 8]);
      if (with_data) for (int i = 3; i >= 0; i--) send_byte(wdat[8*i +: 8]);
   endtask

   task automatic wait_bytes(input int n, input int budget, input string tag);
      int k;
      k = 0;
      while ((tx_q.size() < n) && (k < budget)) begin
         @(negedge clk);
         k++;
      end
      check(tag, 32'(tx_q.size()), 32'(n));
   endtask

   task automatic clear_q();
      tx_q.delete();
      start_q.delete();
   endtask

   task automatic check_write(input string tag, input int exp_cnt, input logic [31:0] addr,
                              input logic [31:0] wdat);
      int lat;
      wait_bytes(1, 400, {tag, "_ack_count"});
      lat = we_cyc - last_start;
      check({tag, "_we_count"}, 32'(we_cnt), 32'(exp_cnt));
      check({tag, "_waddr"}, we_addr, addr);
      check({tag, "_data"}, we_data, wdat);
      check({tag, "_sel"}, 32'(we_sel), 32'hF);
      check({tag, "_we_latency_ok"}, 32'((lat >= 78) && (lat <= 80)), 32'd1);
      check({tag, "_ack_byte"}, q_byte(0), 32'h4B);
      check({tag, "_ack_start"}, 32'(q_start(0) - we_cyc), 32'd1);
      repeat (20) @(negedge clk);
      check({tag, "_busy_low"}, 32'(busy_o), 32'd0);
      clear_q();
   endtask

   task automatic check_read(input string tag, input int exp_cnt, input logic [31:0] addr);
      int lat;
      wait_bytes(4, 800, {tag, "_resp_count"});
      lat = rd_cyc - last_start;
      repeat (10) @(negedge clk);
      check({tag, "_rd_count"}, 32'(rd_cnt), 32'(exp_cnt));
      check({tag, "_raddr"}, rd_addr, addr);
      check({tag, "_rd_latency_ok"}, 32'((lat >= 78) && (lat <= 80)), 32'd1);
      check({tag, "_byte0"}, q_byte(0), 32'h00);
      check({tag, "_byte1"}, q_byte(1), 32'h00);
      check({tag, "_byte2"}, q_byte(2), 32'h00);
      check({tag, "_byte3"}, q_byte(3), 32'hA5);
      check({tag, "_resp_start"}, 32'(q_start(0) - rd_cyc), 32'd2);
      for (int i = 1; i < 4; i++) check({tag, "_b2b_gap"}, 32'(q_start(i) - q_start(i - 1)), 32'd80);
      check({tag, "_busy_fall"}, 32'(busy_fall_cyc - q_start(3)), 32'd80);
      check({tag, "_busy_low"}, 32'(busy_o), 32'd0);
      clear_q();
   endtask

   initial begin
      rst = 1'b1;
      repeat (5) @(negedge clk);
      check("rst_tx_pin", 32'(tx_pin), 32'd1);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_we", 32'(we_o), 32'd0);
      check("rst_rd", 32'(rd_o), 32'd0);
      check("rst_sel", 32'(sel_o), 32'd0);
      check("rst_waddr", waddr_o, 32'd0);
      check("rst_raddr", raddr_o, 32'd0);
      check("rst_data", data_o, 32'd0);
      rst = 1'b0;
      repeat (20) @(negedge clk);

      // Write 0x00000002 to 0x40000004
      send_cmd(8'h57, 32'h4000_0004, 32'h0000_0002, 1'b1);
      check_write("wr", 1, 32'h4000_0004, 32'h0000_0002);
      check("wr_raddr_shared", raddr_o, 32'h4000_0004);
      check("wr_data_held", data_o, 32'h0000_0002);

      // Read from 0x40000010
      send_cmd(8'h52, 32'h4000_0010, 32'h0, 1'b0);
      check_read("rd", 1, 32'h4000_0010);
      check("rd_no_write", 32'(we_cnt), 32'd1);

      // Framing error on the 4th byte of a write frame
      send_byte(8'h57);
      send_byte(8'h40);
      send_byte(8'h00);
      send_byte(8'h00, 1'b0);
      repeat (30) @(negedge clk);
      check("ferr_idle", 32'(busy_o), 32'd0);
      send_cmd(8'h52, 32'h4000_0020, 32'h0, 1'b0);
      check_read("ferr_rd", 2, 32'h4000_0020);
      check("ferr_no_write", 32'(we_cnt), 32'd1);

      // Timeout inside ADDR
      send_byte(8'h52);
      send_byte(8'h40);
      repeat (300) @(negedge clk);
      check("to_still_busy", 32'(busy_o), 32'd1);
      repeat (30) @(negedge clk);
      check("to_idle", 32'(busy_o), 32'd0);
      check("to_no_read", 32'(rd_cnt), 32'd2);

      // Unknown command byte, then a valid write
      send_byte(8'h33);
      repeat (5) @(negedge clk);
      check("unk_idle", 32'(busy_o), 32'd0);
      send_cmd(8'h57, 32'h4000_0008, 32'h0000_0005, 1'b1);
      check_write("unk_wr", 2, 32'h4000_0008, 32'h0000_0005);
      check("unk_no_read", 32'(rd_cnt), 32'd2);

      // Reset during the second response byte
      send_cmd(8'h52, 32'h4000_0030, 32'h0, 1'b0);
      wait_bytes(1, 400, "rstr_first_byte");
      repeat (20) @(negedge clk);
      check("rstr_pre_busy", 32'(busy_o), 32'd1);
      check("rstr_pre_tx", 32'(tx_pin), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      check("rstr_tx_pin", 32'(tx_pin), 32'd1);
      check("rstr_busy", 32'(busy_o), 32'd0);
      check("rstr_raddr", raddr_o, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      clear_q();
      send_cmd(8'h57, 32'h4000_000C, 32'h0000_0007, 1'b1);
      check_write("rstr_wr", 3, 32'h4000_000C, 32'h0000_0007);

      check("sel_only_with_we", 32'(sel_bad), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got no end expected end");
      $fatal(1, "watchdog");
   end

endmodule
